pipe_stage_reg: RTL and testbench
=================================

Name: pipe_stage_reg

Overview:
- Generic elastic pipeline register replacing the fixed IF/ID latch between any two RV32IM pipeline stages (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Carries an opaque DATA_W-bit payload, for example {PC, instruction}.
- Uses a valid/ready handshake with a one-entry skid buffer, so a stall from downstream is absorbed without a combinational ready path back upstream.
- Supports synchronous flush that inserts a bubble, for branch and jump redirects.

Parameters:
- DATA_W, 64, payload width in bits.
- BUBBLE_DATA, 64'h0000_0000_0000_0013, value driven on OUT_DATA when empty, flushed or reset. The low word is the RV32 NOP (addi x0,x0,0).
- CNT_W, 32, width of the performance counters (used only with the optional feature).

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- RESET  in  1  synchronous, active-high reset.
- FLUSH  in  1  synchronous kill of all held and incoming beats.
- IN_VALID  in  1  upstream beat present.
- IN_READY  out  1  this stage can accept a beat; driven directly from a register.
- IN_DATA  in  DATA_W  upstream payload.
- OUT_VALID  out  1  beat presented downstream.
- OUT_READY  in  1  downstream accepts the beat.
- OUT_DATA  out  DATA_W  downstream payload; registered.
- OUT_BUBBLE  out  1  high when OUT_VALID=0 (decode may treat the stage as a NOP).
- STALL_CNT  out  CNT_W  cycles with OUT_VALID=1 and OUT_READY=0 (present only with the optional feature).
- FLUSH_CNT  out  CNT_W  number of flushes that killed at least one valid beat (present only with the optional feature).

Behaviour:
- Storage: main register {m_valid, m_data} drives the OUT_* ports; skid register {s_valid, s_data}.
- State encoding:
  - EMPTY: m_valid=0, s_valid=0.
  - ONE: m_valid=1, s_valid=0.
  - FULL: m_valid=1, s_valid=1.
- Handshake definitions:
  - Accept (acc) = IN_VALID & IN_READY.
  - Drain (drn) = OUT_VALID & OUT_READY.
- Port drive:
  - IN_READY = !s_valid, registered.
  - OUT_VALID = m_valid.
  - OUT_BUBBLE = !m_valid.
- Transitions (evaluated when RESET=0 and FLUSH=0):
  - EMPTY, acc: main <= IN_DATA; go to ONE. Input-to-output latency is exactly 1 cycle.
  - EMPTY, no acc: stay in EMPTY.
  - ONE, acc & drn: main <= IN_DATA; stay in ONE. Sustains full throughput of 1 beat per cycle.
  - ONE, acc & !drn: skid <= IN_DATA; go to FULL; IN_READY falls next cycle.
  - ONE, !acc & drn: go to EMPTY; OUT_DATA <= BUBBLE_DATA.
  - ONE, !acc & !drn: hold.
  - FULL, drn: main <= skid; go to ONE; IN_READY rises next cycle.
  - FULL, !drn: hold; no accept is possible because IN_READY=0.
- Stability rule: while OUT_VALID=1 and OUT_READY=0, OUT_DATA is held bit-stable.
- Ordering: beats leave in arrival order; no beat is duplicated or dropped except by flush.
- FLUSH=1:
  - Next state is EMPTY, OUT_DATA <= BUBBLE_DATA, IN_READY <= 1.
  - Any beat accepted in the same cycle is discarded.
  - FLUSH has priority over acc and drn.
  - The downstream handshake in the flush cycle still completes for the beat currently on OUT_*.
- RESET=1: same result as FLUSH, applied every cycle RESET is high, including mid-stall. Counters clear to 0.
- Reset values: OUT_VALID=0, OUT_DATA=BUBBLE_DATA, OUT_BUBBLE=1, IN_READY=1, STALL_CNT=0, FLUSH_CNT=0.
- X handling: IN_DATA may be X while IN_VALID=0 and is never captured in that case.

Optional Feature:
- Macro: PIPE_STAGE_PERF_CNT_EN.
- Defined:
  - STALL_CNT increments each cycle with OUT_VALID & !OUT_READY & !FLUSH.
  - FLUSH_CNT increments on FLUSH when m_valid or s_valid was set, or when acc occurred that cycle.
  - Both counters saturate at all-ones and clear on RESET.
- Undefined: the counter ports and their logic are absent; all other behaviour is identical.

Decomposition:
- Package pipe_pkg holds:
  - RV32_NOP constant (32'h0000_0013).
  - Default widths, including PC_W=32 and INSTR_W=32.
  - State encoding constants ST_EMPTY, ST_ONE, ST_FULL.
- Sub-module sat_counter (CNT_W parameter; inc, clr, q) instantiated twice, only under the macro.
- Stage wrappers (if_id, id_ex, ...) instantiate pipe_stage_reg with concatenated payloads.

Test Plan:
- Reset and empty:
  - RESET high for 3 cycles mid-transfer -> OUT_VALID=0, OUT_DATA=64'h13, IN_READY=1 on the cycle after release.
  - No beats while IN_VALID=0.
- Streaming:
  - IN_VALID=1 with payloads 0x1000_0000_0000_0001..0x...0008 and OUT_READY=1 -> same 8 beats on OUT_DATA, each 1 cycle later, one per cycle.
- Backpressure and skid:
  - Hold OUT_READY=0 from beat 2 -> beat 3 lands in skid; IN_READY=0 the next cycle; OUT_DATA stays at beat 2.
  - Release OUT_READY -> beats 2, 3, 4 emerge in order with no loss.
- Flush:
  - Assert FLUSH in FULL state while IN_VALID=1 (payload 0xDEAD) -> next cycle OUT_VALID=0, IN_READY=1, and 0xDEAD never appears on the output.
- Random:
  - 10k cycles of random IN_VALID, OUT_READY and FLUSH against a scoreboard -> ordering preserved, stability rule holds, and IN_READY=!s_valid throughout.
- Perf counters (with PIPE_STAGE_PERF_CNT_EN, CNT_W=4):
  - 20 stall cycles -> STALL_CNT=4'hF (saturated).
  - One flush of a valid beat -> FLUSH_CNT=1.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared constants and types for the RV32IM pipeline register slice.
package pipe_pkg;

  localparam int unsigned PC_W       = 32;
  localparam int unsigned INSTR_W    = 32;
  localparam int unsigned DATA_W_DEF = PC_W + INSTR_W;
  localparam int unsigned CNT_W_DEF  = 32;

  // addi x0,x0,0
  localparam logic [31:0] RV32_NOP = 32'h0000_0013;

  // Encoded as {m_valid, s_valid} so occupancy reads straight off the state.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_ONE   = 2'b10,
    ST_FULL  = 2'b11
  } stage_state_e;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; used for stage perf counters.
module sat_counter #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             CLK,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [CNT_W-1:0] q_o
);

  logic [CNT_W-1:0] cnt_q;

  // Count up on inc, stick at all-ones, clear has priority.
  always_ff @(posedge CLK) begin
    if (clr_i) begin
      cnt_q <= '0;
    end else if (inc_i && (cnt_q != '1)) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign q_o = cnt_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Elastic pipeline register with a one-entry skid buffer and synchronous flush.
// Optional perf counters (STALL_CNT, FLUSH_CNT) when PIPE_STAGE_PERF_CNT_EN is defined.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int unsigned       DATA_W      = DATA_W_DEF,
  parameter logic [DATA_W-1:0] BUBBLE_DATA = DATA_W'(RV32_NOP)
`ifdef PIPE_STAGE_PERF_CNT_EN
  ,
  parameter int unsigned       CNT_W       = CNT_W_DEF
`endif
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              FLUSH,
  input  logic              IN_VALID,
  output logic              IN_READY,
  input  logic [DATA_W-1:0] IN_DATA,
  output logic              OUT_VALID,
  input  logic              OUT_READY,
  output logic [DATA_W-1:0] OUT_DATA,
  output logic              OUT_BUBBLE
`ifdef PIPE_STAGE_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]  STALL_CNT,
  output logic [CNT_W-1:0]  FLUSH_CNT
`endif
);

  stage_state_e      state_q, state_d;
  logic [DATA_W-1:0] m_data_q, m_data_d;
  logic [DATA_W-1:0] s_data_q, s_data_d;
  logic              in_ready_q, in_ready_d;
  logic              m_valid;
  logic              acc;
  logic              drn;

  assign m_valid = (state_q != ST_EMPTY);
  assign acc     = IN_VALID & in_ready_q;
  assign drn     = m_valid & OUT_READY;

  // Next-state and datapath selection; flush overrides any accept/drain.
  always_comb begin
    state_d  = state_q;
    m_data_d = m_data_q;
    s_data_d = s_data_q;
    if (FLUSH) begin
      state_d  = ST_EMPTY;
      m_data_d = BUBBLE_DATA;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (acc) begin
            m_data_d = IN_DATA;
            state_d  = ST_ONE;
          end
        end
        ST_ONE: begin
          if (acc && drn) begin
            m_data_d = IN_DATA;
          end else if (acc) begin
            s_data_d = IN_DATA;
            state_d  = ST_FULL;
          end else if (drn) begin
            m_data_d = BUBBLE_DATA;
            state_d  = ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (drn) begin
            m_data_d = s_data_q;
            state_d  = ST_ONE;
          end
        end
        default: begin
          state_d  = ST_EMPTY;
          m_data_d = BUBBLE_DATA;
        end
      endcase
    end
    // Ready is precomputed from next occupancy so IN_READY is a flop output.
    in_ready_d = (state_d != ST_FULL);
  end

  // State and payload registers with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q    <= ST_EMPTY;
      m_data_q   <= BUBBLE_DATA;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      m_data_q   <= m_data_d;
      s_data_q   <= s_data_d;
      in_ready_q <= in_ready_d;
    end
  end

  assign IN_READY   = in_ready_q;
  assign OUT_VALID  = m_valid;
  assign OUT_BUBBLE = ~m_valid;
  assign OUT_DATA   = m_data_q;

`ifdef PIPE_STAGE_PERF_CNT_EN
  logic stall_inc;
  logic flush_inc;

  // s_valid implies m_valid, so m_valid alone covers any held beat.
  assign stall_inc = m_valid & ~OUT_READY & ~FLUSH;
  assign flush_inc = FLUSH & (m_valid | acc);

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .CLK   (CLK),
    .clr_i (RESET),
    .inc_i (stall_inc),
    .q_o   (STALL_CNT)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .CLK   (CLK),
    .clr_i (RESET),
    .inc_i (flush_inc),
    .q_o   (FLUSH_CNT)
  );
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Scoreboard bench for pipe_stage_reg: a two-deep FIFO reference model tracks
// expected beats; a negedge monitor compares every DUT output each cycle.
module tb_pipe_stage_reg;

  localparam logic [63:0] BUB  = 64'h0000_0000_0000_0013;
  localparam logic [63:0] DEAD = 64'h0000_0000_0000_DEAD;
`ifdef PIPE_STAGE_PERF_CNT_EN
  localparam int unsigned CW   = 4;
  localparam int unsigned CMAX = 15;
`endif

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, in_ready, out_valid, out_ready, out_bubble;
  logic [63:0] in_data, out_data;
`ifdef PIPE_STAGE_PERF_CNT_EN
  logic [CW-1:0] stall_cnt, flush_cnt;
`endif

  always #5 clk = ~clk;

`ifdef PIPE_STAGE_PERF_CNT_EN
  pipe_stage_reg #(.DATA_W(64), .BUBBLE_DATA(BUB), .CNT_W(CW)) dut (
`else
  pipe_stage_reg #(.DATA_W(64), .BUBBLE_DATA(BUB)) dut (
`endif
    .CLK        (clk),
    .RESET      (rst),
    .FLUSH      (flush),
    .IN_VALID   (in_valid),
    .IN_READY   (in_ready),
    .IN_DATA    (in_data),
    .OUT_VALID  (out_valid),
    .OUT_READY  (out_ready),
    .OUT_DATA   (out_data),
    .OUT_BUBBLE (out_bubble)
`ifdef PIPE_STAGE_PERF_CNT_EN
    ,
    .STALL_CNT  (stall_cnt),
    .FLUSH_CNT  (flush_cnt)
`endif
  );

  int          errors = 0;
  int          checks = 0;
  logic [63:0] sb[$];
  int unsigned stall_m = 0;
  int unsigned flush_m = 0;
  bit          dead_seen = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Reference model: a queue holding at most two beats; ready while below two.
  always @(posedge clk) begin
    bit acc, drn;
    acc = (in_valid === 1'b1) && (sb.size() < 2);
    drn = (sb.size() > 0) && (out_ready === 1'b1);
`ifdef PIPE_STAGE_PERF_CNT_EN
    if (rst) begin
      stall_m = 0;
      flush_m = 0;
    end else begin
      if ((sb.size() > 0) && !out_ready && !flush && stall_m < CMAX) stall_m++;
      if (flush && ((sb.size() > 0) || acc) && flush_m < CMAX) flush_m++;
    end
`endif
    if (rst || flush) begin
      sb.delete();
    end else begin
      if (drn) void'(sb.pop_front());
      if (acc) sb.push_back(in_data);
    end
  end

  // Monitor: outputs are all registered, so sample mid-cycle on the falling edge.
  always @(negedge clk) begin
    chk("out_valid",  {63'd0, out_valid},  {63'd0, sb.size() > 0});
    chk("out_bubble", {63'd0, out_bubble}, {63'd0, sb.size() == 0});
    chk("in_ready",   {63'd0, in_ready},   {63'd0, sb.size() < 2});
    chk("out_data",   out_data,            (sb.size() > 0) ? sb[0] : BUB);
`ifdef PIPE_STAGE_PERF_CNT_EN
    chk("stall_cnt",  64'(stall_cnt),      64'(stall_m));
    chk("flush_cnt",  64'(flush_cnt),      64'(flush_m));
`endif
    if (out_valid === 1'b1 && out_data === DEAD) dead_seen = 1'b1;
  end

  // Drive one cycle of inputs, then wait for the next falling edge.
  task automatic step(input bit v, input bit r, input bit f, input bit rs, input logic [63:0] d);
    rst       = rs;
    flush     = f;
    in_valid  = v;
    out_ready = r;
    in_data   = d;
    @(negedge clk);
  endtask

  function automatic logic [63:0] beat(input int unsigned n);
    return 64'h1000_0000_0000_0000 | 64'(n);
  endfunction

  initial begin
    // Reset, then idle with undriven payload.
    step(0, 1, 0, 1, 'x);
    step(0, 1, 0, 1, 'x);
    for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 'x);

    // Streaming: eight back-to-back beats.
    for (int unsigned i = 1; i <= 8; i++) step(1, 1, 0, 0, beat(i));
    step(0, 1, 0, 0, 'x);
    step(0, 1, 0, 0, 'x);

    // Backpressure from beat 2: beat 3 skids, beat 4 waits for IN_READY.
    step(1, 1, 0, 0, beat(1));
    step(1, 1, 0, 0, beat(2));
    step(1, 0, 0, 0, beat(3));
    step(1, 0, 0, 0, beat(4));
    step(1, 0, 0, 0, beat(4));
    step(1, 1, 0, 0, beat(4));
    step(1, 1, 0, 0, beat(4));
    for (int i = 0; i < 4; i++) step(0, 1, 0, 0, 'x);

    // Reset held three cycles in the middle of a stall.
    step(1, 1, 0, 0, beat(5));
    step(1, 0, 0, 0, beat(6));
    step(1, 0, 0, 1, beat(7));
    step(1, 0, 0, 1, beat(7));
    step(1, 0, 0, 1, beat(7));
    step(0, 1, 0, 0, 'x);
    step(0, 1, 0, 0, 'x);

    // Flush in FULL with 0xDEAD on the input, then flush in ONE accepting 0xDEAD.
    step(1, 1, 0, 0, beat(9));
    step(1, 0, 0, 0, beat(10));
    step(1, 0, 1, 0, DEAD);
    step(1, 0, 0, 0, beat(11));
    step(1, 1, 1, 0, DEAD);
    for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 'x);

`ifdef PIPE_STAGE_PERF_CNT_EN
    // Saturation of the stall counter and a single counted flush.
    step(0, 1, 0, 1, 'x);
    step(1, 0, 0, 0, beat(12));
    for (int i = 0; i < 20; i++) step(0, 0, 0, 0, 'x);
    chk("stall_cnt_saturated", 64'(stall_cnt), 64'hF);
    step(0, 0, 1, 0, 'x);
    chk("flush_cnt_one", 64'(flush_cnt), 64'h1);
    step(0, 1, 0, 1, 'x);
`endif

    // Random traffic with occasional flush and reset.
    for (int i = 0; i < 10000; i++) begin
      bit          v, r, f, rs;
      logic [63:0] d;
      v  = ($urandom_range(0, 3) != 0);
      r  = ($urandom_range(0, 3) != 0);
      f  = ($urandom_range(0, 31) == 0);
      rs = ($urandom_range(0, 255) == 0);
      d  = {1'b1, 31'($urandom), 32'($urandom)};
      if (!v && $urandom_range(0, 1) == 1) d = 'x;
      step(v, r, f, rs, d);
    end
    step(0, 1, 0, 0, 'x);

    chk("dead_never_out", {63'd0, dead_seen}, 64'd0);

    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
